apb_resp_mem: RTL and testbench
===============================

Name: apb_resp_mem

Overview:
- APB3 completer (responder) at the far end of the AHB-Lite-to-APB path.
- Answers one PSEL line with a word-addressed RAM.
- Wait states are programmable and error responses can be injected.
- Counts completed transfers and flags protocol violations, giving benches a self-checking APB target.

Parameters:
- MEM_WORDS, 256, number of 32-bit words; power of two, 2..4096.
- IDX_LSB, 2, lowest PADDR bit of the word index.
- DEC_BITS, 12, number of PADDR bits decoded. PADDR[31:DEC_BITS] is ignored; an index at or above MEM_WORDS is an error.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  this completer's select.
- PENABLE  in  1  APB access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; valid only when PREADY=1 and PWRITE=0.
- PREADY  out  1  transfer completes in this cycle.
- PSLVERR  out  1  error response; meaningful only with PREADY=1.
- WAIT_CFG  in  4  wait states to insert, sampled in the setup cycle.
- ERR_INJECT  in  1  force an error on the transfer whose setup cycle sees it high.
- ACCESS_CNT  out  16  completed transfers, saturating.
- PROT_ERR  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - FSM goes to IDLE; PRDATA=0, PREADY=0, PSLVERR=0, ACCESS_CNT=0, PROT_ERR=0.
  - RAM contents are retained; power-up contents are undefined.
  - A reset during ACCESS abandons the transfer with no write, and PREADY is 0 in the following cycle.
- FSM states: IDLE, ACCESS.
- IDLE:
  - PSEL=1 with PENABLE=0 is a setup cycle.
  - On that edge, latch the address index PADDR[DEC_BITS-1:IDX_LSB], PWRITE, PWDATA, WAIT_CFG into the down-counter, and ERR_INJECT.
  - Compute err = ERR_INJECT | (index >= MEM_WORDS).
  - Register PRDATA = mem[index] for a read without err, otherwise 0.
  - Go to ACCESS.
- ACCESS:
  - PREADY = (cnt==0), decoded from registers only; PSLVERR = PREADY & err_latched.
  - While cnt != 0 and PENABLE=1, decrement cnt.
  - The cycle with PREADY=1 is the completion cycle:
    - if write and !err, mem[index] <= latched PWDATA;
    - ACCESS_CNT increments unless it is at 16'hFFFF;
    - go to IDLE.
- Latency: completion falls in the (WAIT_CFG+1)-th access-phase cycle. WAIT_CFG=0 gives a standard 2-cycle APB transfer.
- Back-to-back transfers: a new setup cycle is allowed in the cycle right after completion, with no idle gap required.
- Outside ACCESS, PREADY=0 and PSLVERR=0.
- PRDATA holds its value until the next setup cycle latches a new one.
- Protocol checks set PROT_ERR, which holds until reset. After a violation the FSM returns to IDLE without writing and without counting. Violations:
  - PENABLE=1 while in IDLE;
  - PSEL=0 while in ACCESS before completion;
  - PADDR, PWRITE or PWDATA differ from the latched values during ACCESS;
  - PENABLE=0 in ACCESS after the setup cycle.
- Errors: an out-of-range or injected error is a normal completed transfer. It is counted, it never writes, and read data is 0.
- Width rules:
  - The index is DEC_BITS-IDX_LSB bits, compared unsigned against MEM_WORDS.
  - cnt is 4 bits; WAIT_CFG=15 gives 16 access cycles.

Test Plan:
- WAIT_CFG=0: write 0xDEADBEEF to PADDR 0x010, then read 0x010. Each transfer completes in its first access cycle; PRDATA=0xDEADBEEF, PSLVERR=0, ACCESS_CNT=2.
- WAIT_CFG=3: read 0x010. PREADY is low for 3 access cycles and high on the 4th; PRDATA=0xDEADBEEF.
- MEM_WORDS=256: write 0x11111111 to PADDR 0x400 (index 256). PREADY=1 with PSLVERR=1. A read of 0x000 then returns the prior contents, not 0x11111111, and ACCESS_CNT increments.
- ERR_INJECT=1 during the setup of a write of 0x55 to 0x020. PSLVERR=1, and a following read of 0x020 returns the old value.
- PADDR changed from 0x010 to 0x014 mid-wait (WAIT_CFG=2). PROT_ERR=1 and stays set; no write; ACCESS_CNT is unchanged; FSM is back in IDLE.
- PRESET pulsed during the wait of a write (WAIT_CFG=5). All outputs are 0 the next cycle, the target word is unchanged, and a fresh transfer completes normally.

Source files
------------

// File: rtl/apb_resp_mem.sv
// apb_resp_mem: APB3 completer backed by a word-addressed RAM.
//   Answers one PSEL line, inserts a programmable number of wait states,
//   can be told to return an error on a given transfer, counts completed
//   transfers and raises a sticky flag on any APB protocol violation.
// Ports:
//   PCLK, PRESET          clock (rising edge) and synchronous active-high reset
//   PSEL, PENABLE, PWRITE APB control from the requester
//   PADDR, PWDATA         byte address and write data
//   PRDATA, PREADY        read data (registered at setup) and completion strobe
//   PSLVERR               error response, meaningful with PREADY=1
//   WAIT_CFG, ERR_INJECT  wait states / error injection, sampled at setup
//   ACCESS_CNT            completed transfers, saturating at 16'hFFFF
//   PROT_ERR              sticky protocol-violation flag, cleared by reset
module apb_resp_mem #(
  parameter int MEM_WORDS = 256,
  parameter int IDX_LSB   = 2,
  parameter int DEC_BITS  = 12
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic [3:0]  WAIT_CFG,
  input  logic        ERR_INJECT,
  output logic [15:0] ACCESS_CNT,
  output logic        PROT_ERR
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [15:0]    acc_cnt_q, acc_cnt_d;
  logic           prot_err_q, prot_err_d;
  logic [AW-1:0]  mem_idx_q;
  logic [31:0]    paddr_q, pwdata_q, prdata_q;
  logic           pwrite_q, err_q;
  logic [31:0]    mem_q [MEM_WORDS];

  logic           setup_s, viol_s, done_s, mem_we_s, idx_ok_s, setup_err_s;
  logic [31:0]    setup_idx_s;
  logic           pready_s, pslverr_s;

  // Zero-extended word index of the current PADDR; upper PADDR bits are ignored.
  assign setup_idx_s = 32'(PADDR[DEC_BITS-1:IDX_LSB]);
  assign idx_ok_s    = (setup_idx_s < 32'(MEM_WORDS));
  assign setup_err_s = ERR_INJECT | ~idx_ok_s;
  assign setup_s     = (state_q == ST_IDLE) & PSEL & ~PENABLE;
  // A violation always wins over completion, so an aborted transfer never writes.
  assign mem_we_s    = done_s & pwrite_q & ~err_q & ~PRESET;

  // State register plus counters and sticky flag.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      acc_cnt_q  <= 16'd0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      prot_err_q <= prot_err_d;
    end
  end

  // Next-state logic: setup detection, wait countdown, completion and protocol checks.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_cnt_d  = acc_cnt_q;
    prot_err_d = prot_err_q;
    viol_s     = 1'b0;
    done_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && PENABLE) begin
          viol_s = 1'b1;
        end else if (PSEL) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_CFG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!PSEL || !PENABLE || (PADDR != paddr_q) ||
            (PWRITE != pwrite_q) || (PWDATA != pwdata_q)) begin
          viol_s  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (viol_s) begin
      prot_err_d = 1'b1;
    end else begin
      prot_err_d = prot_err_q;
    end
    if (done_s && (acc_cnt_q != 16'hFFFF)) begin
      acc_cnt_d = acc_cnt_q + 16'd1;
    end else begin
      acc_cnt_d = acc_cnt_q;
    end
  end

  // Output decode: completion and error strobes depend on registers only.
  always_comb begin
    pready_s  = 1'b0;
    pslverr_s = 1'b0;
    if (state_q == ST_ACCESS) begin
      pready_s  = (cnt_q == 4'd0);
      pslverr_s = (cnt_q == 4'd0) & err_q;
    end else begin
      pready_s  = 1'b0;
      pslverr_s = 1'b0;
    end
  end

  // Setup-cycle capture of the transfer; PRDATA holds until the next setup.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      mem_idx_q <= '0;
      paddr_q   <= 32'd0;
      pwdata_q  <= 32'd0;
      pwrite_q  <= 1'b0;
      err_q     <= 1'b0;
      prdata_q  <= 32'd0;
    end else if (setup_s) begin
      mem_idx_q <= setup_idx_s[AW-1:0];
      paddr_q   <= PADDR;
      pwdata_q  <= PWDATA;
      pwrite_q  <= PWRITE;
      err_q     <= setup_err_s;
      if (!PWRITE && !setup_err_s) begin
        prdata_q <= mem_q[setup_idx_s[AW-1:0]];
      end else begin
        prdata_q <= 32'd0;
      end
    end
  end

  // RAM write port; contents are not reset.
  always_ff @(posedge PCLK) begin
    if (mem_we_s) begin
      mem_q[mem_idx_q] <= pwdata_q;
    end
  end

  assign PRDATA     = prdata_q;
  assign PREADY     = pready_s;
  assign PSLVERR    = pslverr_s;
  assign ACCESS_CNT = acc_cnt_q;
  assign PROT_ERR   = prot_err_q;

endmodule

// File: tb/tb_apb_resp_mem.sv
// Self-checking bench for apb_resp_mem: directed scenarios followed by
// randomized transfers, all compared against a word-array reference model.
module tb_apb_resp_mem;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE, ERR_INJECT;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, PROT_ERR;
  logic [3:0]  WAIT_CFG;
  logic [15:0] ACCESS_CNT;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] ref_mem [256];
  int          exp_cnt;
  logic        exp_prot;

  apb_resp_mem #(.MEM_WORDS(256), .IDX_LSB(2), .DEC_BITS(12)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .WAIT_CFG(WAIT_CFG),
    .ERR_INJECT(ERR_INJECT), .ACCESS_CNT(ACCESS_CNT), .PROT_ERR(PROT_ERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_status();
    chk("access_cnt", {16'h0, ACCESS_CNT}, 32'(exp_cnt));
    chk("prot_err", {31'h0, PROT_ERR}, {31'h0, exp_prot});
  endtask

  // One complete APB transfer; checks every access cycle and updates the model.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] w, input logic inj);
    int          idx;
    logic        err;
    logic [31:0] exp_rd;
    idx    = int'(addr[11:2]);
    err    = inj || (idx >= 256);
    exp_rd = (!wr && !err) ? ref_mem[idx] : 32'h0;
    @(negedge PCLK);
    check_status();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    WAIT_CFG = w; ERR_INJECT = inj;
    @(negedge PCLK);
    PENABLE = 1'b1; ERR_INJECT = 1'b0; WAIT_CFG = 4'($urandom);
    for (int k = 0; k <= int'(w); k++) begin
      chk("pready", {31'h0, PREADY}, {31'h0, (k == int'(w))});
      if (k == int'(w)) begin
        chk("pslverr", {31'h0, PSLVERR}, {31'h0, err});
        chk("prdata", PRDATA, exp_rd);
      end else begin
        chk("pslverr_wait", {31'h0, PSLVERR}, 32'h0);
        @(negedge PCLK);
      end
    end
    if (wr && !err) ref_mem[idx] = wd;
    if (exp_cnt < 65535) exp_cnt++;
  endtask

  task automatic idle_cyc();
    @(negedge PCLK);
    check_status();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0; WAIT_CFG = 4'h0; ERR_INJECT = 1'b0;
    exp_cnt = 0; exp_prot = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", {31'h0, PREADY}, 32'h0);
    chk("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    check_status();
    PRESET = 1'b0;

    // Basic write/read with no wait states, then a 3-wait read.
    xfer(32'h010, 1'b1, 32'hDEADBEEF, 4'd0, 1'b0);
    xfer(32'h010, 1'b0, 32'h0, 4'd0, 1'b0);
    idle_cyc();
    chk("cnt_after_two", {16'h0, ACCESS_CNT}, 32'd2);
    xfer(32'h010, 1'b0, 32'h0, 4'd3, 1'b0);
    chk("prdata_wait3", PRDATA, 32'hDEADBEEF);

    // Fill the whole RAM so later reads have known contents.
    for (int i = 0; i < 256; i++) xfer(32'(i * 4), 1'b1, $urandom, 4'd0, 1'b0);

    // Out-of-range write (index 256) must error and not alias onto word 0.
    xfer(32'h400, 1'b1, 32'h11111111, 4'd0, 1'b0);
    xfer(32'h000, 1'b0, 32'h0, 4'd1, 1'b0);
    // Injected error on a write leaves the old word in place.
    xfer(32'h020, 1'b1, 32'h55, 4'd0, 1'b1);
    xfer(32'h020, 1'b0, 32'h0, 4'd0, 1'b0);

    // Address changes mid-wait: protocol violation, abort, no write, no count.
    idle_cyc();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h010;
    PWDATA = 32'hCAFEF00D; WAIT_CFG = 4'd2;
    @(negedge PCLK);
    PENABLE = 1'b1;
    chk("viol_pready1", {31'h0, PREADY}, 32'h0);
    @(negedge PCLK);
    chk("viol_pready2", {31'h0, PREADY}, 32'h0);
    PADDR = 32'h014;
    @(negedge PCLK);
    exp_prot = 1'b1;
    check_status();
    chk("viol_idle", {31'h0, PREADY}, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    xfer(32'h010, 1'b0, 32'h0, 4'd0, 1'b0);
    idle_cyc();

    // Reset in the middle of a 5-wait write abandons it.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h030;
    PWDATA = ~ref_mem[12]; WAIT_CFG = 4'd5;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    exp_cnt = 0; exp_prot = 1'b0;
    chk("rst2_pready", {31'h0, PREADY}, 32'h0);
    chk("rst2_pslverr", {31'h0, PSLVERR}, 32'h0);
    chk("rst2_prdata", PRDATA, 32'h0);
    check_status();
    xfer(32'h030, 1'b0, 32'h0, 4'd0, 1'b0);

    // Randomized traffic, including ignored upper address bits and errors.
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[11:10] = 2'b00;
      w = ($urandom_range(9) == 0) ? 4'd15 : 4'($urandom_range(3));
      xfer(a, 1'($urandom_range(1)), $urandom, w, ($urandom_range(7) == 0));
      if ($urandom_range(4) == 0) idle_cyc();
    end
    idle_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
